lsu_mem_ctrl: RTL and testbench

//  Load/store initiator for data_mem: takes one 64-bit load/store request from the datapath and

---
 rtl/lsu_mem_ctrl.sv | 122 ++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for data_mem: one request at a time, split into one or two
// big-endian 32-bit beats, with alignment and range rejection ahead of any memory access.
//
//   state | meaning
//   IDLE  | ready for a request; memory strobes low
//   BEAT0 | first (high) word at addr
//   BEAT1 | second (low) word at addr+4, doubleword only
//   RESP  | one-cycle response pulse
module lsu_mem_ctrl #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_dword,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [63:0]       mem_data_in,
    input  logic [31:0]       mem_data_out,
    output logic              mem_memwrite,
    output logic              mem_memread
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(MEM_BYTES - 4);
    localparam logic [ADDR_W-1:0] LAST_DWORD = ADDR_W'(MEM_BYTES - 8);

    logic [1:0]        state;
    logic              wr_q;
    logic              dw_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic              bad_req;
    logic              in_beat;

    // Range compare on the raw address, so the later +4 can never wrap.
    always_comb begin
        bad_req = 1'b0;
        if (req_dword)
            bad_req = (req_addr[2:0] != 3'd0) || (req_addr > LAST_DWORD);
        else
            bad_req = (req_addr[1:0] != 2'd0) || (req_addr > LAST_WORD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wr_q    <= 1'b0;
            dw_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        dw_q    <= req_dword;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= bad_req;
                        hi_q    <= '0;
                        lo_q    <= '0;
                        state   <= bad_req ? S_RESP : S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    if (!wr_q) hi_q <= mem_data_out;
                    state <= dw_q ? S_BEAT1 : S_RESP;
                end
                S_BEAT1: begin
                    if (!wr_q) lo_q <= mem_data_out;
                    state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory-side outputs depend only on posedge-registered state, so data_mem
    // sees them stable at its negedge sample point.
    always_comb begin
        in_beat      = (state == S_BEAT0) || (state == S_BEAT1);
        req_ready    = (state == S_IDLE);
        mem_memwrite = in_beat && wr_q;
        mem_memread  = in_beat && !wr_q;
        mem_address  = '0;
        mem_data_in  = '0;
        if (state == S_BEAT0) begin
            mem_address = addr_q;
            mem_data_in = {32'd0, (dw_q ? wdata_q[63:32] : wdata_q[31:0])};
        end else if (state == S_BEAT1) begin
            mem_address = addr_q + ADDR_W'(4);
            mem_data_in = {32'd0, wdata_q[31:0]};
        end
    end

    always_comb begin
        resp_valid = (state == S_RESP);
        resp_err   = (state == S_RESP) && err_q;
        resp_rdata = '0;
        if ((state == S_RESP) && !err_q && !wr_q)
            resp_rdata = dw_q ? {hi_q, lo_q} : {{32{hi_q[31]}}, hi_q};
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a byte-array data_mem on the bus, and a separate
// byte-array reference model that predicts each response when the request is accepted.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_dword;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_address;
    logic [63:0] mem_data_in;
    logic [31:0] mem_data_out = 32'd0;
    logic        mem_memwrite;
    logic        mem_memread;

    lsu_mem_ctrl #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_dword    (req_dword),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_memwrite (mem_memwrite),
        .mem_memread  (mem_memread)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        wr;
        logic        dw;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          beats = 0;
    logic        loaded = 1'b0;
    logic [7:0]  dmem    [0:1023];
    logic [7:0]  ref_mem [0:1023];
    int          pre_addr [4] = '{0, 8, 16, 40};
    logic [31:0] pre_val  [4] = '{32'd1000, 32'hFFFFFF38, 32'd300, 32'd3};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // data_mem: samples on negedge, big-endian words
    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 8'd0;
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 4; i++)
                    dmem[pre_addr[k] + i] <= pre_val[k][31-8*i -: 8];
            loaded <= 1'b1;
        end else if (mem_address < 64'd1021) begin
            if (mem_memwrite)
                for (int i = 0; i < 4; i++)
                    dmem[int'(mem_address) + i] <= mem_data_in[31-8*i -: 8];
            if (mem_memread)
                mem_data_out <= {dmem[int'(mem_address)], dmem[int'(mem_address) + 1],
                                 dmem[int'(mem_address) + 2], dmem[int'(mem_address) + 3]};
        end
    end

    // Reference: predict response from byte-level memory contents
    function automatic exp_t model(input logic w, input logic d, input logic [63:0] a,
                                   input logic [63:0] wd);
        exp_t        e;
        int          n;
        logic [63:0] v;
        logic        bad;
        n   = d ? 8 : 4;
        bad = (d ? (a % 8 != 0) : (a % 4 != 0)) || (a > (d ? 64'd1016 : 64'd1020));
        e.err = bad; e.wr = w; e.dw = d; e.addr = a; e.wdata = wd; e.rdata = 64'd0; e.acc = 0;
        if (!bad) begin
            if (w) begin
                for (int i = 0; i < n; i++)
                    ref_mem[int'(a) + i] = wd[8*(n-1-i) +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[int'(a) + i]);
                e.rdata = d ? v : {{32{v[31]}}, v[31:0]};
            end
        end
        return e;
    endfunction

    // Monitor: checks every memory beat and every response against the queue head
    always @(negedge clk) begin
        if (!rst_n) begin
            beats = 0;
        end else begin
            if (mem_memread || mem_memwrite) begin
                if (sb.size() == 0) begin
                    chk("stray_strobe", 64'd1, 64'd0);
                end else begin
                    mon_e = sb[0];
                    chk("strobe_excl", 64'(mem_memread & mem_memwrite), 64'd0);
                    chk("strobe_dir", 64'(mem_memwrite), 64'(mon_e.wr));
                    chk("beat_addr", mem_address, mon_e.addr + 64'(4 * beats));
                    if (mon_e.wr)
                        chk("beat_data", mem_data_in,
                            {32'd0, (mon_e.dw && beats == 0) ? mon_e.wdata[63:32] : mon_e.wdata[31:0]});
                    beats = beats + 1;
                end
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("stray_resp", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("resp_err", 64'(resp_err), 64'(mon_e.err));
                    chk("beat_count", 64'(beats), 64'(mon_e.err ? 0 : (mon_e.dw ? 2 : 1)));
                    chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.err ? 1 : (mon_e.dw ? 3 : 2)));
                    beats = 0;
                end
            end
        end
    end

    // Present a request from a negedge and hold it until accepted; returns the accept index.
    task automatic issue(input logic w, input logic d, input logic [63:0] a,
                         input logic [63:0] wd, output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_dword = d; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 64'd0, 64'd1);
            acc = -1;
            return;
        end
        e = model(w, d, a, wd);
        e.acc = cyc;
        acc = cyc;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a0, a1, a2, acc, n, r;
        logic        w, d;
        logic [63:0] a;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_dword = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++)
                ref_mem[pre_addr[k] + i] = pre_val[k][31-8*i -: 8];
        #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_strobes", 64'({mem_memwrite, mem_memread}), 64'd0);
        chk("rst_mem_addr", mem_address, 64'd0);
        chk("rst_mem_data", mem_data_in, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed: loads of preloaded words
        issue(1'b0, 1'b0, 64'd8, 64'd0, acc);  idle(2);
        issue(1'b0, 1'b0, 64'd0, 64'd0, acc);  idle(2);
        issue(1'b0, 1'b0, 64'd40, 64'd0, acc); idle(2);
        // Doubleword store, read back both ways
        issue(1'b1, 1'b1, 64'd48, 64'h1122334455667788, acc); idle(1);
        issue(1'b0, 1'b1, 64'd48, 64'd0, acc); idle(1);
        issue(1'b0, 1'b0, 64'd52, 64'd0, acc); idle(1);
        // Rejected requests
        issue(1'b0, 1'b0, 64'd6, 64'd0, acc);    idle(1);
        issue(1'b0, 1'b1, 64'd12, 64'd0, acc);   idle(1);
        issue(1'b0, 1'b0, 64'd1024, 64'd0, acc); idle(1);
        issue(1'b0, 1'b1, 64'd1020, 64'd0, acc); idle(1);
        issue(1'b0, 1'b0, 64'd1020, 64'd0, acc); idle(1);
        issue(1'b1, 1'b1, 64'd1016, 64'hA5A5A5A5_5A5A5A5A, acc); idle(1);
        issue(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, acc); idle(1);

        // Back-to-back with req_valid held high
        issue(1'b0, 1'b0, 64'd16, 64'd0, a0);
        issue(1'b0, 1'b0, 64'd0, 64'd0, a1);
        issue(1'b0, 1'b0, 64'd8, 64'd0, a2);
        idle(3);
        chk("b2b_gap1", 64'(a1 - a0), 64'd3);
        chk("b2b_gap2", 64'(a2 - a1), 64'd3);
        issue(1'b0, 1'b1, 64'd48, 64'd0, a0);
        issue(1'b1, 1'b1, 64'd64, 64'h0123456789ABCDEF, a1);
        idle(4);
        chk("b2b_dword_gap", 64'(a1 - a0), 64'd4);

        // Reset during BEAT1 of a doubleword load
        issue(1'b0, 1'b1, 64'd0, 64'd0, acc);
        @(posedge clk);
        #1;
        chk("pre_rst_beat1_addr", mem_address, 64'd4);
        chk("pre_rst_beat1_read", 64'(mem_memread), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes", 64'({mem_memwrite, mem_memread}), 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        chk("midrst_mem_addr", mem_address, 64'd0);
        sb.delete();
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(1'b0, 1'b1, 64'd64, 64'd0, acc); idle(2);

        // Randomized mix
        for (int k = 0; k < 60; k++) begin
            w = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 7)       a = d ? 64'(8 * $urandom_range(0, 127)) : 64'(4 * $urandom_range(0, 255));
            else if (r == 7) a = 64'($urandom_range(0, 1023));
            else if (r == 8) a = 64'($urandom_range(1012, 1060));
            else             a = {$urandom, $urandom};
            issue(w, d, a, {$urandom, $urandom}, acc);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        idle(1);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
